// File: rtl/plic.sv
// Platform-level interrupt controller: per-source priority, pending and enable,
// a threshold, and a claim/complete port behind a one-cycle valid/ready register bus.
module plic #(
   parameter int plic_sources   = 8,
   parameter int plic_prio_bits = 3
) (
   input  logic                    rst,
   input  logic                    clk,
   input  logic                    plic_valid,
   input  logic                    plic_instr,
   input  logic [31:0]             plic_addr,
   input  logic [31:0]             plic_wdata,
   input  logic [3:0]              plic_wstrb,
   output logic [31:0]             plic_rdata,
   output logic                    plic_ready,
   input  logic [plic_sources-1:0] plic_irq,
   output logic                    plic_meip
);

   localparam int IDW = (plic_sources > 2) ? $clog2(plic_sources) : 1;

   // Word offsets (byte offset >> 2) of the non-priority registers.
   localparam logic [19:0] PEND_W  = 20'h00400;
   localparam logic [19:0] EN_W    = 20'h00800;
   localparam logic [19:0] THR_W   = 20'h80000;
   localparam logic [19:0] CLAIM_W = 20'h80001;

   logic [plic_prio_bits-1:0] prio_q [plic_sources];
   logic [plic_prio_bits-1:0] prio_d [plic_sources];
   logic [plic_sources-1:0]   pending_q, pending_d;
   logic [plic_sources-1:0]   enable_q, enable_d;
   logic [plic_sources-1:0]   in_service_q, in_service_d;
   logic [plic_prio_bits-1:0] threshold_q, threshold_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      ready_q, ready_d;
   logic                      meip_q, meip_d;

   logic [19:0]               word_addr;
   logic                      acc;
   logic                      bus_op;
   logic                      is_write;
   logic                      prio_hit;
   logic [IDW-1:0]            prio_idx;
   logic                      cmpl_id_ok;
   logic [IDW-1:0]            cmpl_idx;
   logic [IDW-1:0]            best_id;
   logic [plic_prio_bits-1:0] best_prio;
   logic [31:0]               merged;
   logic                      unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return (old_v & ~m) | (new_v & m);
   endfunction

   // A request is taken only while no response is outstanding, so a master
   // holding valid through the ready cycle produces a single access.
   assign acc        = plic_valid & ~ready_q;
   assign bus_op     = acc & ~plic_instr;
   assign is_write   = |plic_wstrb;
   assign word_addr  = plic_addr[21:2];
   assign prio_hit   = word_addr < 20'(plic_sources);
   assign prio_idx   = word_addr[IDW-1:0];
   assign cmpl_id_ok = (plic_wdata != 32'd0) && (plic_wdata < 32'(plic_sources));
   assign cmpl_idx   = plic_wdata[IDW-1:0];

   assign unused_bits = ^{plic_addr[31:22], plic_addr[1:0], plic_irq[0]};

   // Starting the search at the threshold and replacing only on strictly higher
   // priority gives both the threshold test and lowest-ID tie breaking.
   always_comb begin
      best_id   = '0;
      best_prio = threshold_q;
      for (int i = 1; i < plic_sources; i++) begin
         if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
            best_id   = IDW'(i);
            best_prio = prio_q[i];
         end
      end
   end

   always_comb begin
      prio_d       = prio_q;
      pending_d    = pending_q;
      enable_d     = enable_q;
      in_service_d = in_service_q;
      threshold_d  = threshold_q;
      rdata_d      = '0;
      ready_d      = acc;
      meip_d       = (best_id != '0);
      merged       = '0;

      for (int i = 1; i < plic_sources; i++) begin
         if (plic_irq[i] && !in_service_q[i]) begin
            pending_d[i] = 1'b1;
         end
      end

      if (bus_op) begin
         if (!is_write) begin
            if (prio_hit) begin
               rdata_d = 32'(prio_q[prio_idx]);
            end else begin
               case (word_addr)
                  PEND_W:  rdata_d = 32'(pending_q);
                  EN_W:    rdata_d = 32'(enable_q);
                  THR_W:   rdata_d = 32'(threshold_q);
                  CLAIM_W: begin
                     rdata_d = 32'(best_id);
                     // Applied after the gateway so a same-cycle re-pend loses to the claim.
                     if (best_id != '0) begin
                        pending_d[best_id]    = 1'b0;
                        in_service_d[best_id] = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            if (prio_hit) begin
               if (prio_idx != '0) begin
                  merged           = merge_bytes(32'(prio_q[prio_idx]), plic_wdata, plic_wstrb);
                  prio_d[prio_idx] = merged[plic_prio_bits-1:0];
               end
            end else begin
               case (word_addr)
                  EN_W: begin
                     merged   = merge_bytes(32'(enable_q), plic_wdata, plic_wstrb);
                     enable_d = {merged[plic_sources-1:1], 1'b0};
                  end
                  THR_W: begin
                     merged      = merge_bytes(32'(threshold_q), plic_wdata, plic_wstrb);
                     threshold_d = merged[plic_prio_bits-1:0];
                  end
                  CLAIM_W: begin
                     if (cmpl_id_ok && in_service_q[cmpl_idx]) begin
                        in_service_d[cmpl_idx] = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < plic_sources; i++) begin
            prio_q[i] <= '0;
         end
         pending_q    <= '0;
         enable_q     <= '0;
         in_service_q <= '0;
         threshold_q  <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         meip_q       <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         in_service_q <= in_service_d;
         threshold_q  <= threshold_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         meip_q       <= meip_d;
      end
   end

   assign plic_rdata = rdata_q;
   assign plic_ready = ready_q;
   assign plic_meip  = meip_q;

endmodule

// File: tb/tb_plic.sv
// Bench for plic: a per-edge reference model checked every cycle, plus directed
// register and interrupt scenarios with hand-computed expected values.
module tb_plic;

   localparam int N  = 8;
   localparam int PB = 3;

   localparam logic [31:0] A_PEND = 32'h0000_1000;
   localparam logic [31:0] A_EN   = 32'h0000_2000;
   localparam logic [31:0] A_THR  = 32'h0020_0000;
   localparam logic [31:0] A_CLM  = 32'h0020_0004;

   logic          clk;
   logic          rst;
   logic          plic_valid;
   logic          plic_instr;
   logic [31:0]   plic_addr;
   logic [31:0]   plic_wdata;
   logic [3:0]    plic_wstrb;
   logic [31:0]   plic_rdata;
   logic          plic_ready;
   logic [N-1:0]  plic_irq;
   logic          plic_meip;

   int total = 0;
   int bad   = 0;

   plic #(.plic_sources(N), .plic_prio_bits(PB)) dut (
      .rst        (rst),
      .clk        (clk),
      .plic_valid (plic_valid),
      .plic_instr (plic_instr),
      .plic_addr  (plic_addr),
      .plic_wdata (plic_wdata),
      .plic_wstrb (plic_wstrb),
      .plic_rdata (plic_rdata),
      .plic_ready (plic_ready),
      .plic_irq   (plic_irq),
      .plic_meip  (plic_meip)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [PB-1:0] m_prio [N];
   logic [N-1:0]  m_pend, m_en, m_ins;
   logic [PB-1:0] m_thr;
   logic          m_ready, m_meip;
   logic [31:0]   m_rdata;

   // Scan priorities from highest downwards; first enabled pending source at that level wins.
   function automatic int model_winner();
      for (int p = (1 << PB) - 1; p > int'(m_thr); p--) begin
         for (int i = 1; i < N; i++) begin
            if (m_pend[i] && m_en[i] && int'(m_prio[i]) == p) return i;
         end
      end
      return 0;
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < N; i++) m_prio[i] = '0;
            m_pend = '0; m_en = '0; m_ins = '0; m_thr = '0;
            m_ready = 1'b0; m_meip = 1'b0; m_rdata = '0;
         end else begin
            int w, a, k;
            logic acc;
            logic [N-1:0] np, ni;
            logic [31:0] t;
            w   = model_winner();
            acc = plic_valid && !m_ready;
            m_meip  = (w != 0);
            m_ready = acc;
            m_rdata = '0;
            np = (m_pend | (plic_irq & ~m_ins)) & ~N'(1);
            ni = m_ins;
            if (acc && !plic_instr) begin
               a = int'(plic_addr[21:0]);
               if (plic_wstrb == 4'd0) begin
                  if (a < 4 * N) m_rdata = 32'(m_prio[a / 4]);
                  else if (a == 32'h1000) m_rdata = 32'(m_pend);
                  else if (a == 32'h2000) m_rdata = 32'(m_en);
                  else if (a == 32'h200000) m_rdata = 32'(m_thr);
                  else if (a == 32'h200004) begin
                     m_rdata = 32'(w);
                     if (w != 0) begin
                        np[w] = 1'b0;
                        ni[w] = 1'b1;
                     end
                  end
               end else begin
                  if (a < 4 * N && a >= 4) begin
                     t = lanes(32'(m_prio[a / 4]), plic_wdata, plic_wstrb);
                     m_prio[a / 4] = t[PB-1:0];
                  end else if (a == 32'h2000) begin
                     t = lanes(32'(m_en), plic_wdata, plic_wstrb);
                     m_en = t[N-1:0] & ~N'(1);
                  end else if (a == 32'h200000) begin
                     t = lanes(32'(m_thr), plic_wdata, plic_wstrb);
                     m_thr = t[PB-1:0];
                  end else if (a == 32'h200004) begin
                     k = int'(plic_wdata);
                     if (plic_wdata < 32'(N) && k != 0 && m_ins[k]) ni[k] = 1'b0;
                  end
               end
            end
            m_pend = np;
            m_ins  = ni;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("cyc_ready", 32'(plic_ready), 32'(m_ready));
            check("cyc_meip", 32'(plic_meip), 32'(m_meip));
            if (m_ready) check("cyc_rdata", plic_rdata, m_rdata);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ins, output logic [31:0] rd);
      int n;
      @(negedge clk);
      plic_valid = 1'b1;
      plic_instr = ins;
      plic_addr  = a;
      plic_wdata = d;
      plic_wstrb = s;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!plic_ready && n < 4);
      if (!plic_ready) check("bus_timeout", 32'(plic_ready), 32'd1);
      rd = plic_rdata;
      plic_valid = 1'b0;
      plic_instr = 1'b0;
      plic_wstrb = 4'd0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      bus(a, d, s, 1'b0, dummy);
   endtask

   task automatic bus_rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      bus(a, 32'd0, 4'd0, 1'b0, rd);
      check(name, rd, exp);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int pulses;
      logic [31:0] got, rd;
      rst = 1'b0;
      plic_valid = 1'b0; plic_instr = 1'b0; plic_addr = '0;
      plic_wdata = '0; plic_wstrb = '0; plic_irq = '0;
      #1;
      check("rst_rdata", plic_rdata, 32'd0);
      check("rst_ready", 32'(plic_ready), 32'd0);
      check("rst_meip", 32'(plic_meip), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      bus_rd_chk("rst_prio3", 32'h0C, 32'd0);
      bus_rd_chk("rst_en", A_EN, 32'd0);
      bus_rd_chk("rst_thr", A_THR, 32'd0);
      bus_rd_chk("rst_pend", A_PEND, 32'd0);
      bus_wr(32'h10, 32'hFF, 4'hF);
      bus_rd_chk("prio_trunc", 32'h10, 32'd7);
      bus_wr(32'h14, 32'h0000_0300, 4'b0010);
      bus_rd_chk("prio_lane", 32'h14, 32'd0);
      bus_wr(32'h00, 32'd7, 4'hF);
      bus_rd_chk("prio0_zero", 32'h00, 32'd0);
      bus_wr(A_EN, 32'hFFFF_FFFF, 4'b0001);
      bus_rd_chk("en_mask", A_EN, 32'hFE);
      bus_wr(A_PEND, 32'hFF, 4'hF);
      bus_rd_chk("pend_ro", A_PEND, 32'd0);
      bus_rd_chk("unmapped", 32'h3000, 32'd0);
      bus_wr(A_THR, 32'h0F, 4'hF);
      bus_rd_chk("thr_trunc", A_THR, 32'd7);
      bus_wr(A_THR, 32'd0, 4'hF);
      bus_wr(A_EN, 32'd0, 4'hF);

      // Single source claim flow
      bus_wr(32'h0C, 32'd5, 4'hF);
      bus_wr(A_EN, 32'h08, 4'hF);
      bus_wr(A_THR, 32'd0, 4'hF);
      plic_irq = 8'h08;
      @(negedge clk);
      check("s1_meip_lag", 32'(plic_meip), 32'd0);
      @(negedge clk);
      check("s1_meip", 32'(plic_meip), 32'd1);
      bus_rd_chk("s1_pend", A_PEND, 32'h08);
      bus_rd_chk("s1_claim", A_CLM, 32'd3);
      bus_rd_chk("s1_pend_clr", A_PEND, 32'd0);
      check("s1_meip_clr", 32'(plic_meip), 32'd0);
      plic_irq = 8'h00;
      bus_wr(A_CLM, 32'd3, 4'hF);

      // Equal priority tie
      bus_wr(32'h08, 32'd4, 4'hF);
      bus_wr(32'h14, 32'd4, 4'hF);
      bus_wr(A_EN, 32'h24, 4'hF);
      plic_irq = 8'h24;
      repeat (2) @(negedge clk);
      bus_rd_chk("tie_claim1", A_CLM, 32'd2);
      bus_rd_chk("tie_claim2", A_CLM, 32'd5);
      plic_irq = 8'h00;
      bus_wr(A_CLM, 32'd2, 4'hF);
      bus_wr(A_CLM, 32'd5, 4'hF);

      // Threshold boundary
      bus_wr(A_THR, 32'd4, 4'hF);
      bus_wr(32'h04, 32'd4, 4'hF);
      bus_wr(A_EN, 32'h02, 4'hF);
      plic_irq = 8'h02;
      repeat (2) @(negedge clk);
      check("thr_meip0", 32'(plic_meip), 32'd0);
      bus_rd_chk("thr_claim0", A_CLM, 32'd0);
      bus_rd_chk("thr_pend", A_PEND, 32'h02);
      bus_wr(A_THR, 32'd3, 4'hF);
      @(negedge clk);
      check("thr_meip1", 32'(plic_meip), 32'd1);
      bus_rd_chk("thr_claim1", A_CLM, 32'd1);
      plic_irq = 8'h00;
      bus_wr(A_CLM, 32'd1, 4'hF);

      // Complete with held level
      bus_wr(A_EN, 32'h08, 4'hF);
      bus_wr(A_THR, 32'd0, 4'hF);
      plic_irq = 8'h08;
      repeat (2) @(negedge clk);
      bus_rd_chk("cmp_claim", A_CLM, 32'd3);
      bus_wr(A_CLM, 32'd6, 4'hF);
      bus_rd_chk("cmp_bad_id", A_PEND, 32'd0);
      bus_wr(A_CLM, 32'd3, 4'hF);
      @(negedge clk);
      bus_rd_chk("cmp_repend", A_PEND, 32'h08);
      bus_rd_chk("cmp_claim2", A_CLM, 32'd3);
      plic_irq = 8'h00;
      bus_wr(A_CLM, 32'd3, 4'hF);

      // Held valid and instruction fetch
      plic_irq = 8'h08;
      repeat (2) @(negedge clk);
      @(negedge clk);
      plic_valid = 1'b1; plic_instr = 1'b0; plic_addr = A_CLM; plic_wstrb = 4'd0;
      pulses = 0; got = '0;
      repeat (2) begin
         @(negedge clk);
         if (plic_ready) begin
            pulses++;
            got = plic_rdata;
         end
      end
      plic_valid = 1'b0;
      @(negedge clk);
      if (plic_ready) pulses++;
      check("hold_pulses", 32'(pulses), 32'd1);
      check("hold_claim", got, 32'd3);
      bus_rd_chk("hold_once", A_CLM, 32'd0);
      bus_wr(A_CLM, 32'd3, 4'hF);
      @(negedge clk);
      bus(A_CLM, 32'd0, 4'd0, 1'b1, rd);
      check("instr_rdata", rd, 32'd0);
      bus_rd_chk("instr_pend", A_PEND, 32'h08);
      bus(A_THR, 32'd7, 4'hF, 1'b1, rd);
      bus_rd_chk("instr_thr", A_THR, 32'd0);

      // Reset while a response is outstanding
      @(negedge clk);
      check("pre_rst_meip", 32'(plic_meip), 32'd1);
      plic_valid = 1'b1; plic_addr = 32'h0C; plic_wstrb = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("arst_ready", 32'(plic_ready), 32'd0);
      check("arst_rdata", plic_rdata, 32'd0);
      check("arst_meip", 32'(plic_meip), 32'd0);
      plic_valid = 1'b0;
      plic_irq = 8'h00;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (plic_ready) pulses++;
      end
      check("arst_no_pulse", 32'(pulses), 32'd0);
      rst = 1'b1;
      bus_rd_chk("arst_prio3", 32'h0C, 32'd0);
      bus_rd_chk("arst_en", A_EN, 32'd0);
      bus_rd_chk("arst_pend", A_PEND, 32'd0);
      bus_rd_chk("arst_claim", A_CLM, 32'd0);
      check("arst_meip2", 32'(plic_meip), 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/plic.md
PLIC -- requirements
Module: plic

Interface
REQ-001 SHALL have parameter plic_sources, default 8, meaning the number of interrupt source IDs including reserved ID 0.
REQ-002 SHALL have parameter plic_prio_bits, default 3, meaning the width of each priority field and of the threshold register.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port plic_valid, input, 1, bus request strobe.
REQ-006 SHALL have port plic_instr, input, 1, set when the request is an instruction fetch.
REQ-007 SHALL have port plic_addr, input, 32, byte offset from the PLIC base address.
REQ-008 SHALL have port plic_wdata, input, 32, write data.
REQ-009 SHALL have port plic_wstrb, input, 4, byte write strobes; all zero means a read.
REQ-010 SHALL have port plic_rdata, output, 32, registered read data.
REQ-011 SHALL have port plic_ready, output, 1, registered one-cycle response strobe.
REQ-012 SHALL have port plic_irq, input, plic_sources, level interrupt lines; bit 0 is ignored.
REQ-013 SHALL have port plic_meip, output, 1, registered machine external interrupt request to the cpu.

Function
REQ-014 SHALL accept an access when plic_valid=1 and plic_ready=0, and SHALL drive plic_ready=1 for exactly one cycle on the next edge.
REQ-015 SHALL ignore plic_valid while plic_ready=1, so that holding the request through the response cycle causes no second access or side effect.
REQ-016 SHALL decode plic_addr[21:0] as follows: 0x000000+4*i is priority[i]; 0x001000 is pending (RO); 0x002000 is enable; 0x200000 is threshold; 0x200004 is claim/complete.
REQ-017 SHALL treat priority[0], pending bit 0 and enable bit 0 as hardwired zero.
REQ-018 SHALL write each register only in byte lanes with plic_wstrb set; priority and threshold SHALL keep only their low plic_prio_bits bits, and enable only bits plic_sources-1:1.
REQ-019 SHALL ignore writes to pending and to unmapped offsets; unmapped reads SHALL return 0; ready SHALL still be returned.
REQ-020 SHALL, for an access with plic_instr=1, return rdata=0 with ready and have no side effects.
REQ-021 SHALL keep a per-source in-service flag; the gateway SHALL set pending[i] on an edge where plic_irq[i]=1, pending[i]=0 and in_service[i]=0.
REQ-022 SHALL select the winner as the source with pending&enable set and priority>threshold having the highest priority, with ties resolved to the lowest ID; winner ID 0 means none.
REQ-023 SHALL, on an accepted claim read, return the winner ID in rdata and, in the same edge, clear pending[winner] and set in_service[winner]; if the winner is 0, the read SHALL return 0 with no state change.
REQ-024 SHALL, on an accepted complete write with nonzero wstrb, clear in_service[wdata] if wdata is a valid ID with in_service set, and otherwise ignore the write.
REQ-025 SHALL, when a claim and a gateway set of the same source occur in one cycle, let the claim win: pending=0 and in_service=1.
REQ-026 SHALL register plic_meip as (winner != 0), so that it reflects the state one cycle after any change to pending, enable, priority or threshold.
REQ-027 SHALL let a source whose irq remains high after completion re-pend on the edge after completion.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear priority, pending, enable, threshold, in_service, plic_rdata, plic_ready and plic_meip.
REQ-029 SHALL, when reset is asserted mid-access, discard the pending response; ready SHALL not be asserted for that access.

Verification
REQ-030 Set priority[3]=5, enable=0x08, threshold=0, then raise irq[3] -> pending=0x08 next edge; meip=1 one edge later; claim returns 3; pending=0; meip=0.
REQ-031 Set priority[2]=4 and priority[5]=4, enable both, and raise both irqs -> the first claim returns 2 and the second claim returns 5.
REQ-032 Set threshold=4 with priority[1]=4 pending and enabled -> meip=0 and claim returns 0 with pending unchanged; setting threshold=3 -> meip=1.
REQ-033 Claim source 3 with irq[3] held high, then write complete 6 (not in service) -> no change; then write complete 3 -> pending[3]=1 on the following edge.
REQ-034 Hold plic_valid high for two cycles on a claim read -> exactly one ready pulse and one claim; an access with plic_instr=1 -> rdata=0 and no state change.
REQ-035 Assert rst=0 asynchronously mid-access with state set -> all registers, ready and meip read 0 immediately, and no ready pulse follows.
